// File: rtl/joy_sega_scan.sv
// Sega 3/6-button and Master System pad scanner for two ports.
// A fixed step sequence on the shared select line decodes both pads into 12-bit words.
module joy_sega_scan #(
  parameter int STEP_DIV    = 1536,
  parameter int FRAME_STEPS = 256
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [5:0]  joy1_i,
  input  logic [5:0]  joy2_i,
  output logic        joy_p7_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        md1_o,
  output logic        md2_o,
  output logic        six1_o,
  output logic        six2_o,
  output logic        frame_o
);

  localparam int DW = $clog2(STEP_DIV);
  localparam int SW = $clog2(FRAME_STEPS);
  localparam logic [DW-1:0] DIV_LAST  = DW'(STEP_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(FRAME_STEPS - 1);

  logic [1:0][5:0]  sync1_q, sync1_d;
  logic [1:0][5:0]  sync2_q, sync2_d;
  logic [DW-1:0]    div_q, div_d;
  logic [SW-1:0]    step_q, step_d;
  logic             p7_q, p7_d;
  logic [1:0][11:0] sh_q, sh_d;
  logic [1:0]       smd_q, smd_d;
  logic [1:0]       ssix_q, ssix_d;
  logic [1:0][11:0] out_q, out_d;
  logic [1:0]       md_q, md_d;
  logic [1:0]       six_q, six_d;
  logic             frame_q, frame_d;
  logic             step_end;

  assign step_end = (div_q == DIV_LAST);

  always_comb begin
    sync1_d = {joy2_i, joy1_i};
    sync2_d = sync1_q;
    div_d   = step_end ? '0 : div_q + DW'(1);
    step_d  = step_q;
    sh_d    = sh_q;
    smd_d   = smd_q;
    ssix_d  = ssix_q;
    out_d   = out_q;
    md_d    = md_q;
    six_d   = six_q;
    frame_d = 1'b0;

    if (step_end)
      step_d = (step_q == STEP_LAST) ? '0 : step_q + SW'(1);

    // select level of the step that starts at this edge
    p7_d = (step_d < SW'(7)) ? step_d[0] : 1'b1;

    if (step_end) begin
      for (int p = 0; p < 2; p++) begin
        unique case (1'b1)
          (step_q == SW'(2)): begin
            sh_d[p][5:0] = sync2_q[p];
            smd_d[p]     = 1'b0;
            ssix_d[p]    = 1'b0;
          end
          (step_q == SW'(3)): begin
            if (sync2_q[p][3:2] == 2'b00) begin
              smd_d[p]     = 1'b1;
              sh_d[p][7:6] = sync2_q[p][5:4];
            end else begin
              sh_d[p][7:4] = {2'b11, sync2_q[p][5:4]};
            end
          end
          (step_q == SW'(5)): begin
            if (sync2_q[p][3:0] == 4'b0000 && smd_q[p])
              ssix_d[p] = 1'b1;
          end
          (step_q == SW'(6)): begin
            sh_d[p][11:8] = ssix_q[p] ? sync2_q[p][3:0] : 4'hF;
          end
          default: ;
        endcase
      end

      if (step_q == STEP_LAST) begin
        out_d   = sh_q;
        md_d    = smd_q;
        six_d   = ssix_q;
        frame_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      div_q   <= '0;
      step_q  <= '0;
      p7_q    <= 1'b1;
      sh_q    <= '1;
      smd_q   <= '0;
      ssix_q  <= '0;
      out_q   <= '1;
      md_q    <= '0;
      six_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      div_q   <= div_d;
      step_q  <= step_d;
      p7_q    <= p7_d;
      sh_q    <= sh_d;
      smd_q   <= smd_d;
      ssix_q  <= ssix_d;
      out_q   <= out_d;
      md_q    <= md_d;
      six_q   <= six_d;
      frame_q <= frame_d;
    end
  end

  assign joy_p7_o = p7_q;
  assign joy1_o   = out_q[0];
  assign joy2_o   = out_q[1];
  assign md1_o    = md_q[0];
  assign md2_o    = md_q[1];
  assign six1_o   = six_q[0];
  assign six2_o   = six_q[1];
  assign frame_o  = frame_q;

endmodule

// File: tb/tb_joy_sega_scan.sv
// Randomized pad scenarios for joy_sega_scan.
// Expected frames are queued at frame start and matched on each frame_o pulse.
module tb_joy_sega_scan;

  localparam int SD   = 4;
  localparam int FS   = 8;
  localparam int FP   = SD * FS;
  localparam int NF   = 40;
  localparam int RSTF = 17;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  joy1_i, joy2_i;
  logic        joy_p7_o;
  logic [11:0] joy1_o, joy2_o;
  logic        md1_o, md2_o, six1_o, six2_o, frame_o;

  typedef struct packed {
    logic [11:0] j1;
    logic [11:0] j2;
    logic        m1;
    logic        m2;
    logic        s1;
    logic        s2;
  } res_t;

  localparam res_t RST_RES = '{j1: 12'hFFF, j2: 12'hFFF, m1: 1'b0, m2: 1'b0, s1: 1'b0, s2: 1'b0};

  res_t       sb[$];
  res_t       exp_hold = RST_RES;
  int         npass = 0;
  int         nchk  = 0;
  logic [5:0] tab1[8];
  logic [5:0] tab2[8];
  bit         rst_at_edge = 1'b1;
  int         k = 7;
  logic       p7_prev = 1'b1;
  int         ncyc = 0;
  int         since = 0;

  joy_sega_scan #(.STEP_DIV(SD), .FRAME_STEPS(FS)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .joy1_i  (joy1_i),
    .joy2_i  (joy2_i),
    .joy_p7_o(joy_p7_o),
    .joy1_o  (joy1_o),
    .joy2_o  (joy2_o),
    .md1_o   (md1_o),
    .md2_o   (md2_o),
    .six1_o  (six1_o),
    .six2_o  (six2_o),
    .frame_o (frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Decoded result of one port given the pins seen in steps 2, 3, 5 and 6.
  function automatic logic [13:0] decode(input logic [5:0] t2, input logic [5:0] t3,
                                         input logic [5:0] t5, input logic [5:0] t6);
    logic md, six;
    logic [11:0] j;
    md  = (t3[3:2] == 2'b00);
    six = md && (t5[3:0] == 4'b0000);
    j   = {six ? t6[3:0] : 4'hF,
           md ? t3[5:4] : 2'b11,
           md ? t2[5:4] : t3[5:4],
           t2[3:0]};
    return {md, six, j};
  endfunction

  task automatic new_frame(input bit idle);
    logic [13:0] d1, d2;
    res_t e;
    for (int i = 0; i < 8; i++) begin
      tab1[i] = idle ? 6'h3F : 6'($urandom);
      tab2[i] = idle ? 6'h3F : 6'($urandom);
    end
    if (!idle) begin
      if ($urandom_range(0, 3) != 0) tab1[3][3:2] = 2'b00;
      if ($urandom_range(0, 3) != 0) tab2[3][3:2] = 2'b00;
      if ($urandom_range(0, 2) != 0) tab1[5][3:0] = 4'h0;
      if ($urandom_range(0, 2) != 0) tab2[5][3:0] = 4'h0;
    end
    d1 = decode(tab1[2], tab1[3], tab1[5], tab1[6]);
    d2 = decode(tab2[2], tab2[3], tab2[5], tab2[6]);
    e  = '{j1: d1[11:0], j2: d2[11:0], m1: d1[13], m2: d2[13], s1: d1[12], s2: d2[12]};
    sb.push_back(e);
  endtask

  always @(posedge clk) rst_at_edge <= reset;

  // Pad model: pins follow the count of select transitions since the frame began.
  always @(negedge clk) begin
    if (rst_at_edge) begin
      k = 7;
    end else if (joy_p7_o !== p7_prev) begin
      if (!joy_p7_o && k >= 7) k = 0;
      else if (k < 7) k++;
    end
    p7_prev = joy_p7_o;
    joy1_i  = tab1[k];
    joy2_i  = tab2[k];
  end

  always @(negedge clk) begin
    res_t cur;
    res_t e;
    int   st;
    cur = '{j1: joy1_o, j2: joy2_o, m1: md1_o, m2: md2_o, s1: six1_o, s2: six2_o};
    if (rst_at_edge) begin
      chk("reset_state", {2'b00, cur, frame_o, joy_p7_o}, {2'b00, RST_RES, 1'b0, 1'b1});
      ncyc     = 0;
      since    = 0;
      exp_hold = RST_RES;
    end else begin
      ncyc++;
      since++;
      st = (ncyc / SD) % FS;
      chk("p7_level", {31'd0, joy_p7_o}, (st < 7) ? 32'(st & 1) : 32'd1);
      if (frame_o) begin
        chk("frame_period", since, FP);
        since = 0;
        if (sb.size() == 0) begin
          nchk++;
          $display("FAIL frame_unexpected: got frame_o=1 expected no publish");
        end else begin
          e = sb.pop_front();
          chk("joy1", {20'd0, cur.j1}, {20'd0, e.j1});
          chk("joy2", {20'd0, cur.j2}, {20'd0, e.j2});
          chk("flags", {28'd0, cur.m1, cur.m2, cur.s1, cur.s2},
                       {28'd0, e.m1, e.m2, e.s1, e.s2});
          exp_hold = e;
        end
      end else begin
        chk("hold", {4'd0, cur}, {4'd0, exp_hold});
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      tab1[i] = 6'h3F;
      tab2[i] = 6'h3F;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int f = 0; f < NF; f++) begin
      new_frame(f == 0);
      if (f == RSTF) begin
        repeat (5 * SD + 1) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        new_frame(1'b0);
      end
      repeat (FP) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
